oam_dma: RTL



---
 rtl/nes_bus_pkg.sv | 21 ++
 rtl/oam_dma_if.sv | 43 ++++
 rtl/oam_dma.sv | 100 ++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus constants and the sprite-DMA state type.
// Used by the DMA engine and by the memory-map decoder.
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR_C = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR_C = 16'h2004;
  localparam int          OAM_BYTES      = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_GET,
    S_PUT
  } dma_state_e;

  function automatic logic is_dma_xfer(dma_state_e s);
    return (s == S_GET) || (s == S_PUT);
  endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side snoop inputs and DMA bus-master outputs of the sprite DMA.
// master = the DMA engine, slave = CPU/bus-mux side.
interface oam_dma_if;

  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;

  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rw;
  logic [7:0]  dma_wdata;
  logic        busy;

  modport master (
    input  cpu_addr,
    input  cpu_wdata,
    input  cpu_rw,
    input  bus_rdata,
    output cpu_rdy,
    output dma_active,
    output dma_addr,
    output dma_rw,
    output dma_wdata,
    output busy
  );

  modport slave (
    output cpu_addr,
    output cpu_wdata,
    output cpu_rw,
    output bus_rdata,
    input  cpu_rdy,
    input  dma_active,
    input  dma_addr,
    input  dma_rw,
    input  dma_wdata,
    input  busy
  );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: snoops $4014 writes, stalls the CPU and copies one
// 256-byte page into OAM with alternating GET/PUT bus cycles.
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_C,
  parameter logic [15:0] OAMDATA_ADDR = OAMDATA_ADDR_C
) (
  input  logic      clk,
  input  logic      rst,
  oam_dma_if.master bus
);

  dma_state_e  state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  latch_q, latch_d;
  logic        trig;

  // Only IDLE snoops, so DMA's own OAMDATA writes never retrigger.
  assign trig = (state_q == S_IDLE)
              && !bus.cpu_rw
              && (bus.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      page_q   <= 8'h00;
      cnt_q    <= 8'h00;
      latch_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          page_d  = bus.cpu_wdata;
          cnt_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // GET must land on parity 0; parity flips at this edge.
        if (bus.cpu_rw) begin
          state_d = parity_q ? S_GET : S_ALIGN;
        end
      end
      S_ALIGN: begin
        state_d = S_GET;
      end
      S_GET: begin
        latch_d = bus.bus_rdata;
        state_d = S_PUT;
      end
      S_PUT: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == 8'hFF) ? S_IDLE : S_GET;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.cpu_rdy    = (state_q == S_IDLE);
    bus.busy       = (state_q != S_IDLE);
    bus.dma_active = is_dma_xfer(state_q);
    bus.dma_addr   = 16'h0000;
    bus.dma_rw     = 1'b1;
    bus.dma_wdata  = 8'h00;
    unique case (state_q)
      S_GET: begin
        bus.dma_addr = {page_q, cnt_q};
      end
      S_PUT: begin
        bus.dma_addr  = OAMDATA_ADDR;
        bus.dma_rw    = 1'b0;
        bus.dma_wdata = latch_q;
      end
      default: begin
        bus.dma_addr = 16'h0000;
      end
    endcase
  end

endmodule
